// File: rtl/row_serializer_if.sv
// Row-in / pixel-out handshake bundle for row_serializer.
// Master is the producer/consumer side; slave is the serializer itself.
interface row_serializer_if #(
  parameter int PIXEL_W = 8,
  parameter int NUM_PIX = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_PIX*PIXEL_W-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [PIXEL_W-1:0]         out_data;
  logic                       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/row_serializer.sv
// Parallel-in, serial-out pixel unloader: one packed row in, one pixel per clock out,
// oldest (MS lane) first, with a one-row holding buffer so consecutive rows stream gap-free.
module row_serializer #(
  parameter int PIXEL_W = 8,
  parameter int NUM_PIX = 16
) (
  input  logic             clk,
  input  logic             reset,
  row_serializer_if.slave  bus,
  output logic             busy
);
  localparam int ROW_W = NUM_PIX * PIXEL_W;
  localparam int CNT_W = $clog2(NUM_PIX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACT      = 2'd1,
    ST_ACT_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   act_q, act_d;
  logic [ROW_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic out_valid_s;
  logic in_ready_s;
  logic accept_s;
  logic pop_s;
  logic end_row_s;

  assign out_valid_s = (state_q != ST_IDLE);
  assign in_ready_s  = (state_q != ST_ACT_HOLD);
  assign accept_s    = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;
  assign end_row_s   = pop_s & (cnt_q == CNT_LAST);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = act_q[ROW_W-1 -: PIXEL_W];
  assign bus.out_last  = out_valid_s & (cnt_q == CNT_LAST);
  assign busy          = out_valid_s;

  // Next-state: shift on pop, then let the state decide whether a new row lands in act or hold.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    if (pop_s) begin
      act_d = act_q << PIXEL_W;
      if (end_row_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      act_d = act_q;
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          act_d   = bus.in_data;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ACT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACT: begin
        if (accept_s && !end_row_s) begin
          hold_d  = bus.in_data;
          state_d = ST_ACT_HOLD;
        end else if (accept_s) begin
          // Row ends and a new one arrives in the same cycle: bypass hold, no bubble.
          act_d   = bus.in_data;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ACT;
        end else if (end_row_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACT;
        end
      end
      ST_ACT_HOLD: begin
        if (end_row_s) begin
          act_d   = hold_q;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ACT;
        end else begin
          state_d = ST_ACT_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        act_d   = {ROW_W{1'b0}};
        hold_d  = {ROW_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, row buffers and pixel counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      act_q   <= {ROW_W{1'b0}};
      hold_q  <= {ROW_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_row_serializer.sv
// Bench for row_serializer: directed vector table on a 4x8 instance, hand sequences for reset,
// and a randomized run on the default 16x8 instance against a pixel-queue reference model.
module tb_row_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy4;
  logic busy16;

  row_serializer_if #(.PIXEL_W(8), .NUM_PIX(4))  bus4 ();
  row_serializer_if #(.PIXEL_W(8), .NUM_PIX(16)) bus16 ();

  row_serializer #(.PIXEL_W(8), .NUM_PIX(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4),
    .busy  (busy4)
  );

  row_serializer #(.PIXEL_W(8), .NUM_PIX(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16),
    .busy  (busy16)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic        last;
    logic        ir;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [31:0] data, input logic ordy,
                         input logic ov, input logic [7:0] od, input logic last,
                         input logic ir, input logic bsy);
    vec_t v;
    v.iv = iv; v.data = data; v.ordy = ordy;
    v.ov = ov; v.od = od; v.last = last; v.ir = ir; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] obs4();
    return {bus4.out_valid, bus4.out_data, bus4.out_last, bus4.in_ready, busy4};
  endfunction

  function automatic logic [11:0] obs16();
    return {bus16.out_valid, bus16.out_data, bus16.out_last, bus16.in_ready, busy16};
  endfunction

  localparam logic [11:0] IDLE_OBS = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [7:0]   q[$];
    logic [127:0] row16;
    logic         iv16, ordy16, exp_ir, exp_ov, exp_last;
    logic [7:0]   exp_od;
    int           pops, cycles, rows;

    bus4.in_valid = 1'b0; bus4.in_data = 32'h0; bus4.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_data = 128'h0; bus16.out_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus4.in_valid  = 1'($urandom);
      bus4.in_data   = $urandom;
      bus4.out_ready = 1'($urandom);
      #1;
      check($sformatf("reset_hold%0d", i), 64'(obs4()), 64'(IDLE_OBS));
    end
    @(negedge clk);
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_release", 64'(obs4()), 64'(IDLE_OBS));

    // iv, data, ordy | ov, od, last, ir, busy
    add_vec(1'b1, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // back-to-back rows, in_valid held; data offered while not ready must be ignored
    add_vec(1'b1, 32'hA1A2A3A4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 32'hB1B2B3B4, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1);
    add_vec(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 32'hEEEEEEEE, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 32'hDDDDDDDD, 1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 32'hC1C2C3C4, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'hC4, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // backpressure: out_ready 1,0,0,1,...
    add_vec(1'b1, 32'h11223344, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus4.in_valid  = vecs[i].iv;
      bus4.in_data   = vecs[i].data;
      bus4.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), 64'(obs4()),
            64'({vecs[i].ov, vecs[i].od, vecs[i].last, vecs[i].ir, vecs[i].bsy}));
    end

    // Reset mid-row after two pops
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.in_data = 32'h11223344; bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    #1;
    check("mid_p0", 64'(obs4()), 64'({1'b1, 8'h11, 1'b0, 1'b1, 1'b1}));
    @(negedge clk);
    #1;
    check("mid_p1", 64'(obs4()), 64'({1'b1, 8'h22, 1'b0, 1'b1, 1'b1}));
    @(negedge clk);
    #1;
    check("mid_p2", 64'(obs4()), 64'({1'b1, 8'h33, 1'b0, 1'b1, 1'b1}));
    #1;
    reset = 1'b0;
    #1;
    check("mid_async_clear", 64'(obs4()), 64'(IDLE_OBS));
    @(negedge clk);
    reset = 1'b1;
    bus4.in_valid = 1'b1; bus4.in_data = 32'h55667788; bus4.out_ready = 1'b1;
    #1;
    check("mid_idle", 64'(obs4()), 64'(IDLE_OBS));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus4.in_valid = 1'b0;
      #1;
      check($sformatf("mid_new%0d", k), 64'(obs4()),
            64'({1'b1, 8'(8'h55 + 8'(k) * 8'h11), (k == 3), 1'b1, 1'b1}));
    end
    @(negedge clk);
    #1;
    check("mid_done", 64'(obs4()), 64'(IDLE_OBS));

    // Randomized 16x8 run against a pixel-queue model
    pops = 0;
    cycles = 0;
    while (pops < 10000 && cycles < 60000) begin
      @(negedge clk);
      iv16   = ($urandom_range(0, 9) < 7);
      ordy16 = ($urandom_range(0, 9) < 7);
      row16  = {$urandom, $urandom, $urandom, $urandom};
      bus16.in_valid  = iv16;
      bus16.in_data   = row16;
      bus16.out_ready = ordy16;
      #1;
      rows     = (q.size() + 15) / 16;
      exp_ir   = (rows < 2);
      exp_ov   = (q.size() != 0);
      exp_od   = exp_ov ? q[0] : 8'h00;
      exp_last = exp_ov && ((q.size() % 16) == 1);
      check("rand16", 64'(obs16()), 64'({exp_ov, exp_od, exp_last, exp_ir, exp_ov}));
      @(posedge clk);
      if (exp_ov && ordy16) begin
        void'(q.pop_front());
        pops++;
      end
      if (iv16 && exp_ir) begin
        for (int k = 0; k < 16; k++) begin
          q.push_back(row16[127 - 8*k -: 8]);
        end
      end
      cycles++;
    end
    check("rand16_pixel_count", 64'(pops >= 10000), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
